// File: rtl/ej32_obuf_tx.sv
// Output-buffer reader for the eJ32 byte bus: prefetches bytes with one-cycle-latency
// reads into a small FIFO and streams them out on a valid/ready byte channel.
module ej32_obuf_tx #(
  parameter int ASZ      = 17,
  parameter int DEPTH    = 4,
  parameter bit STOP_NUL = 1'b1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [ASZ-1:0] base,
  input  logic [15:0]    len,
  input  logic           abort,
  output logic           busy,
  output logic           done,
  output logic [15:0]    sent,
  output logic           mem_rd,
  output logic [ASZ-1:0] mem_addr,
  input  logic [7:0]     mem_di,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready,
  output logic [1:0]     dbg_state_o
);

  // tx channel: a byte moves when tx_valid & tx_ready in the same cycle; while
  // tx_valid is high and tx_ready low, tx_valid and tx_data hold their values.

  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0]     S_IDLE = 2'd0;
  localparam logic [1:0]     S_RUN  = 2'd1;
  localparam logic [1:0]     S_FIN  = 2'd2;
  localparam logic [AW:0]    DEPTH_C = DEPTH[AW:0];
  localparam logic [AW:0]    CONE    = 1;
  localparam logic [AW-1:0]  PONE    = 1;
  localparam logic [ASZ-1:0] AONE    = 1;

  logic [1:0]     state_q, state_d;
  logic [ASZ-1:0] ptr_q, ptr_d;
  logic [15:0]    remain_q, remain_d;
  logic [15:0]    sent_q, sent_d;
  logic           inflight_q, inflight_d;
  logic           term_q, term_d;
  logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]    count_q, count_d;
  logic [7:0]     fifo_q [DEPTH];

  logic in_run, ret_now, nul_now, push, pop, flush, issue;

  assign in_run  = (state_q == S_RUN);
  assign ret_now = in_run && inflight_q && !abort;
  assign nul_now = STOP_NUL && inflight_q && (mem_di == 8'h00);
  assign push    = ret_now && !nul_now;
  assign pop     = tx_valid && tx_ready;
  assign flush   = in_run && abort;
  // A NUL arriving this cycle already blocks the next read, so no address past it is fetched.
  assign issue   = in_run && (remain_q != 16'd0) && !term_q && !nul_now &&
                   ((count_q + {{AW{1'b0}}, inflight_q}) < DEPTH_C);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    remain_d   = remain_q;
    sent_d     = sent_q;
    term_d     = term_q;
    inflight_d = issue && !abort;
    wr_d       = wr_q;
    rd_d       = rd_q;
    count_d    = count_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ptr_d    = base;
          remain_d = len;
          sent_d   = 16'd0;
          term_d   = 1'b0;
          state_d  = (len == 16'd0) ? S_FIN : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          ptr_d    = ptr_q + AONE;
          remain_d = remain_q - 16'd1;
        end
        if (ret_now && nul_now) term_d = 1'b1;
        if (pop && (sent_q != 16'hFFFF)) sent_d = sent_q + 16'd1;
        if (abort) state_d = S_FIN;
        else if ((count_q == '0) && (term_q || ((remain_q == 16'd0) && !inflight_q)))
          state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) wr_d = wr_q + PONE;
      if (pop)  rd_d = rd_q + PONE;
      case ({push, pop})
        2'b10:   count_d = count_q + CONE;
        2'b01:   count_d = count_q - CONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ptr_q      <= '0;
      remain_q   <= '0;
      sent_q     <= '0;
      inflight_q <= 1'b0;
      term_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      remain_q   <= remain_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
      term_q     <= term_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= 8'h00;
    end else if (push) begin
      fifo_q[wr_q] <= mem_di;
    end
  end

  assign busy        = in_run;
  assign done        = (state_q == S_FIN);
  assign sent        = sent_q;
  assign mem_rd      = issue;
  assign mem_addr    = ptr_q;
  assign tx_valid    = (count_q != '0);
  assign tx_data     = tx_valid ? fifo_q[rd_q] : 8'h00;
  assign dbg_state_o = state_q;

endmodule
